// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the BCD digit width.
package alu_seq_pkg;

    localparam int BCD_DIG = 4;

    typedef enum logic [3:0] {
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_BIT,
        ALU_SR,
        ALU_SL,
        ALU_ADD,
        ALU_SUB,
        ALU_CMP
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        DEC,
        DONE
    } alu_state_t;

    // Only ADD and SUB honour the decimal flag; every other op takes the binary path.
    function automatic logic is_dec_op(alu_op_t op, logic dec);
        return dec && (op == ALU_ADD || op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the operand muxes (master) and the ALU (slave).
interface alu_seq_if #(parameter int WIDTH = 8) ();
    import alu_seq_pkg::*;

    // Handshake: a request is accepted on a clock edge where start && ready. Operands are
    // sampled only on that edge. valid is a one-cycle pulse marking the cycle in which
    // out/N/V/Z/C carry the new result; they hold until the next valid.
    logic             start;
    alu_op_t          op;
    logic             dec;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic             ci;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] out;
    logic             N;
    logic             V;
    logic             Z;
    logic             C;

    modport master (
        output start, op, dec, ai, bi, ci,
        input  ready, valid, out, N, V, Z, C
    );

    modport slave (
        input  start, op, dec, ai, bi, ci,
        output ready, valid, out, N, V, Z, C
    );

endinterface

// File: rtl/alu_seq_bcd_digit.sv
// One 4-bit decimal digit stage: add with +6 correction or subtract with +10 correction.
module alu_seq_bcd_digit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] sum;
    logic [4:0] diff;

    // diff spans -16..15, so bit 4 is the sign of a - b - borrow.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        diff = {1'b0, a} - {1'b0, b} - {4'b0, ~cin};
        s    = '0;
        cout = 1'b0;
        if (sub) begin
            if (diff[4]) begin
                s    = diff[3:0] + 4'd10;
                cout = 1'b0;
            end else begin
                s    = diff[3:0];
                cout = 1'b1;
            end
        end else if (sum > 5'd9) begin
            s    = sum[3:0] + 4'd6;
            cout = 1'b1;
        end else begin
            s    = sum[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle binary ops, nibble-serial decimal ADD/SUB processing
// DPC digits per cycle; first digit group is consumed on the accept edge.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DPC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus,
    output alu_state_t dbg_state
);

    localparam int GW = BCD_DIG * DPC;
    localparam int NG = WIDTH / GW;
    localparam int CW = $clog2(NG + 1);

    alu_state_t       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             sub_r;
    logic             dv;
    logic [CW-1:0]    cnt;

    // Binary datapath, evaluated straight from the bus for the accept edge.
    logic [WIDTH-1:0] opv;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH:0]   sum;
    logic             cin_eff;
    logic             bin_c;
    logic             bin_n;
    logic             bin_v;
    logic             bin_z;

    always_comb begin
        opv     = bus.ai | bus.bi;
        cin_eff = (bus.op == ALU_CMP) ? 1'b1 : bus.ci;
        bb      = (bus.op == ALU_SUB || bus.op == ALU_CMP) ? ~bus.bi : bus.bi;
        sum     = {1'b0, bus.ai} + {1'b0, bb} + {{WIDTH{1'b0}}, cin_eff};
        bin_out = '0;
        bin_c   = 1'b0;
        case (bus.op)
            ALU_AND, ALU_BIT:          bin_out = bus.ai & bus.bi;
            ALU_OR:                    bin_out = bus.ai | bus.bi;
            ALU_XOR:                   bin_out = bus.ai ^ bus.bi;
            ALU_SR:                    {bin_out, bin_c} = {bus.ci, opv};
            ALU_SL:                    {bin_c, bin_out} = {opv, bus.ci};
            ALU_ADD, ALU_SUB, ALU_CMP: {bin_c, bin_out} = sum;
            default:                   bin_out = '0;
        endcase
        bin_n = bin_out[WIDTH-1];
        bin_z = ~|bin_out;
        bin_v = (bus.ai[WIDTH-1] ^ bin_out[WIDTH-1]) & (bb[WIDTH-1] ^ bin_out[WIDTH-1]);
        if (bus.op == ALU_BIT) begin
            bin_n = bus.bi[WIDTH-1];
            bin_v = bus.bi[WIDTH-2];
        end
        if (bus.op == ALU_CMP) bin_v = 1'b0;
    end

    // Decimal digit chain: fed from the bus in IDLE, from the shift registers in DEC.
    logic [GW-1:0]    da;
    logic [GW-1:0]    db;
    logic             dsub;
    logic [DPC:0]     chain;
    logic [GW-1:0]    grp;
    logic [WIDTH-1:0] dec_res;

    assign da       = (state == IDLE) ? bus.ai[GW-1:0] : a_sh[GW-1:0];
    assign db       = (state == IDLE) ? bus.bi[GW-1:0] : b_sh[GW-1:0];
    assign dsub     = (state == IDLE) ? (bus.op == ALU_SUB) : sub_r;
    assign chain[0] = (state == IDLE) ? bus.ci : cy;
    assign dec_res  = (res >> GW) | (WIDTH'(grp) << (WIDTH - GW));

    for (genvar g = 0; g < DPC; g++) begin : g_digit
        alu_seq_bcd_digit u_digit (
            .a    (da[4*g +: 4]),
            .b    (db[4*g +: 4]),
            .cin  (chain[g]),
            .sub  (dsub),
            .s    (grp[4*g +: 4]),
            .cout (chain[g+1])
        );
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
            bus.valid <= 1'b0;
            bus.out   <= '0;
            bus.N     <= 1'b0;
            bus.V     <= 1'b0;
            bus.Z     <= 1'b0;
            bus.C     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            cy        <= 1'b0;
            sub_r     <= 1'b0;
            dv        <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.valid <= 1'b0;
                    if (bus.start) begin
                        bus.ready <= 1'b0;
                        if (is_dec_op(bus.op, bus.dec)) begin
                            a_sh  <= bus.ai >> GW;
                            b_sh  <= bus.bi >> GW;
                            res   <= dec_res;
                            cy    <= chain[DPC];
                            sub_r <= (bus.op == ALU_SUB);
                            dv    <= bin_v;
                            cnt   <= CW'(1);
                            if (NG == 1) begin
                                bus.out   <= dec_res;
                                bus.N     <= dec_res[WIDTH-1];
                                bus.Z     <= ~|dec_res;
                                bus.C     <= chain[DPC];
                                bus.V     <= bin_v;
                                bus.valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                state <= DEC;
                            end
                        end else begin
                            bus.out   <= bin_out;
                            bus.N     <= bin_n;
                            bus.V     <= bin_v;
                            bus.Z     <= bin_z;
                            bus.C     <= bin_c;
                            bus.valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DEC: begin
                    a_sh <= a_sh >> GW;
                    b_sh <= b_sh >> GW;
                    res  <= dec_res;
                    cy   <= chain[DPC];
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(NG - 1)) begin
                        bus.out   <= dec_res;
                        bus.N     <= dec_res[WIDTH-1];
                        bus.Z     <= ~|dec_res;
                        bus.C     <= chain[DPC];
                        bus.V     <= dv;
                        bus.valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    bus.valid <= 1'b0;
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    bus.valid <= 1'b0;
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: three instances (W8/DPC1, W16/DPC2, W16/DPC1), random traffic against an
// arithmetic reference model through per-instance expected queues, plus directed corner cases.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst_c;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  ia ();
    alu_seq_if #(.WIDTH(16)) ib ();
    alu_seq_if #(.WIDTH(16)) ic ();

    alu_state_t sa;
    alu_state_t sb;
    alu_state_t sc;

    alu_seq #(.WIDTH(8),  .DPC(1)) dut_a (.clk(clk), .rst(rst),   .bus(ia.slave), .dbg_state(sa));
    alu_seq #(.WIDTH(16), .DPC(2)) dut_b (.clk(clk), .rst(rst),   .bus(ib.slave), .dbg_state(sb));
    alu_seq #(.WIDTH(16), .DPC(1)) dut_c (.clk(clk), .rst(rst_c), .bus(ic.slave), .dbg_state(sc));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected response word: {out[15:0], N, V, Z, C}.
    logic [19:0] exp_qa[$];
    logic [19:0] exp_qb[$];
    int          lat_qa[$];
    int          lat_qb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain integer arithmetic, decimal handled digit by digit.
    function automatic logic [19:0] model(input alu_op_t op, input logic d, input int unsigned a,
                                          input int unsigned b, input logic ci, input int w);
        int unsigned mask;
        int unsigned msb;
        int unsigned r;
        int unsigned sh;
        int unsigned t;
        int unsigned bb;
        int          cy;
        int          s;
        int          da;
        int          db;
        logic        cin;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
        mask = (32'd1 << w) - 32'd1;
        msb  = 32'd1 << (w - 1);
        r    = 0;
        c    = 1'b0;
        cin  = (op == ALU_CMP) ? 1'b1 : ci;
        bb   = (op == ALU_SUB || op == ALU_CMP) ? (~b & mask) : b;
        sh   = a | b;
        case (op)
            ALU_AND, ALU_BIT: r = a & b;
            ALU_OR:           r = a | b;
            ALU_XOR:          r = a ^ b;
            ALU_SR: begin
                r = (ci ? msb : 0) | (sh >> 1);
                c = (sh & 1) != 0;
            end
            ALU_SL: begin
                r = ((sh << 1) | {31'd0, ci}) & mask;
                c = (sh & msb) != 0;
            end
            default: begin
                t = a + bb + {31'd0, cin};
                r = t & mask;
                c = ((t >> w) & 1) != 0;
            end
        endcase
        v = ((a ^ r) & (bb ^ r) & msb) != 0;
        if (d && (op == ALU_ADD || op == ALU_SUB)) begin
            r  = 0;
            cy = ci ? 1 : 0;
            for (int k = 0; k < w / 4; k++) begin
                da = int'((a >> (4 * k)) & 15);
                db = int'((b >> (4 * k)) & 15);
                if (op == ALU_ADD) begin
                    s = da + db + cy;
                    if (s > 9) begin
                        s  = s + 6;
                        cy = 1;
                    end else begin
                        cy = 0;
                    end
                end else begin
                    s = da - db - (1 - cy);
                    if (s < 0) begin
                        s  = s + 10;
                        cy = 0;
                    end else begin
                        cy = 1;
                    end
                end
                r = r | (unsigned'(s & 15) << (4 * k));
            end
            c = (cy != 0);
        end
        if (op == ALU_CMP) v = 1'b0;
        n = (r & msb) != 0;
        z = (r == 0);
        if (op == ALU_BIT) begin
            n = (b & msb) != 0;
            v = ((b >> (w - 2)) & 1) != 0;
        end
        return {r[15:0], n, v, z, c};
    endfunction

    task automatic drive(input int sel, input logic s, input alu_op_t op, input logic d,
                         input logic [15:0] a, input logic [15:0] b, input logic c);
        if (sel == 0) begin
            ia.start = s; ia.op = op; ia.dec = d; ia.ai = a[7:0]; ia.bi = b[7:0]; ia.ci = c;
        end else if (sel == 1) begin
            ib.start = s; ib.op = op; ib.dec = d; ib.ai = a; ib.bi = b; ib.ci = c;
        end else begin
            ic.start = s; ic.op = op; ic.dec = d; ic.ai = a; ic.bi = b; ic.ci = c;
        end
    endtask

    task automatic drive_junk(input int sel, input logic s);
        drive(sel, s, alu_op_t'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
              16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ia.ready : (sel == 1) ? ib.ready : ic.ready;
    endfunction

    function automatic logic vld(input int sel);
        return (sel == 0) ? ia.valid : (sel == 1) ? ib.valid : ic.valid;
    endfunction

    // Issue one request; with hold set, start stays high with fresh junk while busy.
    task automatic issue(input int sel, input alu_op_t op, input logic d, input logic [15:0] a_in,
                         input logic [15:0] b_in, input logic c, input logic hold);
        int          w;
        int          dpc;
        int          lat;
        int          n;
        logic [15:0] a;
        logic [15:0] b;
        w   = (sel == 0) ? 8 : 16;
        dpc = (sel == 1) ? 2 : 1;
        a   = (sel == 0) ? {8'h00, a_in[7:0]} : a_in;
        b   = (sel == 0) ? {8'h00, b_in[7:0]} : b_in;
        n   = 0;
        while (!rdy(sel) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy(sel)) begin
            total++;
            bad++;
            $display("FAIL ready_timeout sel=%0d: got ready=0 expected ready=1", sel);
            return;
        end
        lat = (d && (op == ALU_ADD || op == ALU_SUB)) ? w / (4 * dpc) : 1;
        if (sel == 0) begin
            exp_qa.push_back(model(op, d, a, b, c, w));
            lat_qa.push_back(cyc + lat);
        end else if (sel == 1) begin
            exp_qb.push_back(model(op, d, a, b, c, w));
            lat_qb.push_back(cyc + lat);
        end
        drive(sel, 1'b1, op, d, a, b, c);
        @(posedge clk); #1;
        if (hold) begin
            for (int i = 0; i < lat; i++) begin
                drive_junk(sel, 1'b1);
                @(posedge clk); #1;
            end
        end
        drive_junk(sel, 1'b0);
    endtask

    task automatic wait_valid(input int sel, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld(sel) && n < 30);
        if (!vld(sel)) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got valid=0 expected valid=1", name);
        end
    endtask

    // Monitors: pop and compare whenever a DUT presents valid.
    logic [19:0] ea;
    logic [19:0] eb;
    int          la;
    int          lb;

    always @(negedge clk) begin
        if (!rst && ia.valid) begin
            if (exp_qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_valid: got valid=1 expected no result pending");
            end else begin
                ea = exp_qa.pop_front();
                la = lat_qa.pop_front();
                check("a_result", {12'h000, ia.out, ia.N, ia.V, ia.Z, ia.C}, {12'h000, ea});
                check("a_latency", cyc, la);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ib.valid) begin
            if (exp_qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_valid: got valid=1 expected no result pending");
            end else begin
                eb = exp_qb.pop_front();
                lb = lat_qb.pop_front();
                check("b_result", {12'h000, ib.out, ib.N, ib.V, ib.Z, ib.C}, {12'h000, eb});
                check("b_latency", cyc, lb);
            end
        end
    end

    initial begin
        int      vcount;
        int      n;
        int      sel;
        alu_op_t op;
        logic [15:0] a;
        logic [15:0] b;

        rst   = 1'b1;
        rst_c = 1'b1;
        drive(0, 1'b0, ALU_AND, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, ALU_AND, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(2, 1'b0, ALU_AND, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        // start during reset must be ignored
        drive(0, 1'b1, ALU_ADD, 1'b0, 16'h0011, 16'h0022, 1'b1);
        @(posedge clk); #1;
        check("reset_wins_ready", ia.ready, 1'b1);
        check("reset_wins_state", sa, IDLE);
        drive(0, 1'b0, ALU_AND, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
        rst   = 1'b0;
        rst_c = 1'b0;
        @(negedge clk);
        check("reset_a", {ia.ready, ia.valid, ia.out, ia.N, ia.V, ia.Z, ia.C}, {2'b10, 8'h00, 4'h0});
        check("reset_b", {ib.ready, ib.valid, ib.out, ib.N, ib.V, ib.Z, ib.C}, {2'b10, 16'h0000, 4'h0});
        check("reset_c", {ic.ready, ic.valid, ic.out, ic.N, ic.V, ic.Z, ic.C}, {2'b10, 16'h0000, 4'h0});
        check("reset_state_b", sb, IDLE);
        @(posedge clk); #1;

        // Directed corner cases with literal expectations.
        issue(0, ALU_ADD, 1'b0, 16'h7F, 16'h01, 1'b0, 1'b0);
        wait_valid(0, "add_ovf");
        check("add_ovf", {ia.out, ia.N, ia.V, ia.Z, ia.C}, {8'h80, 4'b1100});
        issue(0, ALU_ADD, 1'b1, 16'h58, 16'h46, 1'b1, 1'b0);
        wait_valid(0, "dec_add");
        check("dec_add", {ia.out, ia.C}, {8'h05, 1'b1});
        issue(0, ALU_SUB, 1'b1, 16'h12, 16'h21, 1'b1, 1'b0);
        wait_valid(0, "dec_sub");
        check("dec_sub", {ia.out, ia.C}, {8'h91, 1'b0});
        issue(0, ALU_CMP, 1'b0, 16'h40, 16'h40, 1'b0, 1'b0);
        wait_valid(0, "cmp_eq");
        check("cmp_eq", {ia.out, ia.V, ia.Z, ia.C}, {8'h00, 3'b011});
        issue(1, ALU_ADD, 1'b1, 16'h9999, 16'h0001, 1'b0, 1'b0);
        wait_valid(1, "dec_add16");
        check("dec_add16", {ib.out, ib.Z, ib.C}, {16'h0000, 2'b11});
        issue(0, ALU_ADD, 1'b1, 16'h35, 16'h27, 1'b0, 1'b1);
        issue(1, ALU_SUB, 1'b1, 16'h5000, 16'h1234, 1'b1, 1'b1);

        // Random traffic across both scoreboarded instances.
        for (int i = 0; i < 300; i++) begin
            sel = i % 2;
            op  = alu_op_t'($urandom_range(0, 8));
            a   = 16'($urandom);
            b   = (op == ALU_SR || op == ALU_SL) ? 16'h0 : 16'($urandom);
            issue(sel, op, 1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0));
        end

        // Abort a decimal op in its second DEC cycle.
        issue(2, ALU_ADD, 1'b0, 16'h1234, 16'h0001, 1'b0, 1'b0);
        wait_valid(2, "c_bin_add");
        check("c_bin_add", ic.out, 16'h1235);
        @(posedge clk); #1;
        issue(2, ALU_ADD, 1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
        check("abort_in_dec", sc, DEC);
        @(posedge clk); #1;
        rst_c = 1'b1;
        @(posedge clk); #1;
        rst_c = 1'b0;
        check("abort_outputs", {ic.ready, ic.valid, ic.out, ic.N, ic.V, ic.Z, ic.C}, {2'b10, 16'h0000, 4'h0});
        check("abort_state", sc, IDLE);
        vcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (ic.valid) vcount++;
        end
        check("abort_no_valid", vcount, 0);

        n = 0;
        while ((exp_qa.size() != 0 || exp_qb.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain_a", exp_qa.size(), 0);
        check("drain_b", exp_qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
